// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM input sequencer: default sizes, FSM state type, job length helper.
package mvm_pkg;

    localparam int K_DEF     = 8;   // matrix dimension
    localparam int B_DEF     = 12;  // data word width
    localparam int DRAIN_DEF = 10;  // idle cycles after done before the next load

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_LD_M,
        S_STR_M,
        S_LD_V,
        S_STR_V,
        S_GAP,
        S_START,
        S_WAIT,
        S_DRAIN
    } seq_state_t;

    // Words in a full job: K*K matrix (row-major) followed by a K vector.
    function automatic int job_words(input int k);
        return k * k + k;
    endfunction

endpackage

// File: rtl/job_buffer.sv
// Simple dual-port job buffer. The read is registered: the address presented
// in cycle n is available on rd_data in cycle n+1.
module job_buffer #(
    parameter  int DEPTH = 72,
    parameter  int B     = 12,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [B-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [B-1:0]  rd_data
);

    logic [B-1:0] mem [DEPTH];

    // Write port: one word per accepted upstream handshake.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read port: registered data so the word is ready the cycle after the address.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mvm_input_sequencer.sv
// Buffers one complete matrix/vector job from a valid/ready stream, replays it
// gap-free as loadMatrix/loadVector bursts, pulses start, and waits for done
// plus a drain period before accepting the next job.
module mvm_input_sequencer
    import mvm_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int B     = B_DEF,
    parameter int DRAIN = DRAIN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [B-1:0] s_data,
    input  logic                s_with_mat,
    output logic                mvm_load_matrix,
    output logic                mvm_load_vector,
    output logic                mvm_start,
    output logic signed [B-1:0] mvm_data,
    input  logic                mvm_done,
    output logic                busy,
    output logic [15:0]         job_count
);

    localparam int JW = job_words(K);
    localparam int CW = $clog2(JW + 1);
    localparam int DW = $clog2(DRAIN + 1);
    localparam int AW = $clog2(JW);

    localparam logic [CW-1:0] LEN_FULL  = CW'(JW);
    localparam logic [CW-1:0] LEN_VEC   = CW'(K);
    localparam logic [CW-1:0] MAT_WORDS = CW'(K * K);

    seq_state_t      state, state_nx;
    logic            job_mat;
    logic [CW-1:0]   words_in;
    logic [CW-1:0]   rd_ptr;
    logic [DW-1:0]   drain_cnt;
    logic [CW-1:0]   job_len;
    logic            accept;
    logic            last_word;
    logic            rd_en;
    logic [B-1:0]    rd_data;

    // In IDLE the job type is not latched yet, so the first word's flag decides.
    assign job_len   = ((state == S_IDLE) ? s_with_mat : job_mat) ? LEN_FULL : LEN_VEC;
    assign s_ready   = ((state == S_IDLE) || (state == S_FILL)) && (words_in < job_len);
    assign accept    = s_valid && s_ready;
    assign last_word = accept && (words_in == job_len - CW'(1));

    // Issue the read one cycle ahead so word n lands on mvm_data in stream cycle n.
    assign rd_en = (state_nx == S_STR_M) || (state_nx == S_STR_V);

    job_buffer #(.DEPTH(JW), .B(B)) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (words_in[AW-1:0]),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; the load begins the cycle right after the last word lands.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept)                       state_nx = S_FILL;
            S_FILL:  if (last_word)                    state_nx = job_mat ? S_LD_M : S_LD_V;
            S_LD_M:                                    state_nx = S_STR_M;
            S_STR_M: if (rd_ptr == MAT_WORDS)          state_nx = S_LD_V;
            S_LD_V:                                    state_nx = S_STR_V;
            S_STR_V: if (rd_ptr == job_len)            state_nx = S_GAP;
            S_GAP:                                     state_nx = S_START;
            S_START:                                   state_nx = S_WAIT;
            S_WAIT:  if (mvm_done)                     state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt == DW'(DRAIN - 1))  state_nx = S_IDLE;
            default:                                   state_nx = S_IDLE;
        endcase
    end

    // Pointers, job-type latch, drain timer and completed-job counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_in  <= '0;
            rd_ptr    <= '0;
            job_mat   <= 1'b0;
            drain_cnt <= '0;
            job_count <= '0;
        end else begin
            if (state_nx == S_IDLE) words_in <= '0;
            else if (accept)        words_in <= words_in + CW'(1);

            if (state_nx == S_IDLE) rd_ptr <= '0;
            else if (rd_en)         rd_ptr <= rd_ptr + CW'(1);

            if (state == S_IDLE && accept) job_mat <= s_with_mat;

            if (state == S_DRAIN) drain_cnt <= drain_cnt + DW'(1);
            else                  drain_cnt <= '0;

            if (state == S_WAIT && mvm_done) job_count <= job_count + 16'd1;
        end
    end

    // Outputs decoded from the current state; data is forced to zero outside the bursts.
    always_comb begin
        mvm_load_matrix = (state == S_LD_M);
        mvm_load_vector = (state == S_LD_V);
        mvm_start       = (state == S_START);
        mvm_data        = ((state == S_STR_M) || (state == S_STR_V)) ? rd_data : '0;
        busy            = (state != S_IDLE);
    end

endmodule

// File: tb/tb_mvm_input_sequencer.sv
// Scoreboard bench: jobs are queued as they are issued; a monitor acting as the
// MVM core captures bursts, checks them and computes y against a reference model.
module tb_mvm_input_sequencer;

    localparam int K     = 8;
    localparam int B     = 12;
    localparam int DRAIN = 10;
    localparam int JW    = K * K + K;
    localparam int TMO   = 3000;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [B-1:0] s_data = '0;
    logic                s_with_mat = 1'b0;
    logic                mvm_load_matrix, mvm_load_vector, mvm_start;
    logic signed [B-1:0] mvm_data;
    logic                mvm_done = 1'b0;
    logic                busy;
    logic [15:0]         job_count;

    mvm_input_sequencer #(.K(K), .B(B), .DRAIN(DRAIN)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .s_with_mat      (s_with_mat),
        .mvm_load_matrix (mvm_load_matrix),
        .mvm_load_vector (mvm_load_vector),
        .mvm_start       (mvm_start),
        .mvm_data        (mvm_data),
        .mvm_done        (mvm_done),
        .busy            (busy),
        .job_count       (job_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic               with_mat;
        logic [JW-1:0][B-1:0] w;
    } job_t;

    job_t exp_q[$];
    int   last_acc_cyc = -1;
    int   done_pending = 0;
    int   done_delay   = 0;
    bit   spurious_en  = 1'b0;
    bit   waiting      = 1'b0;

    // ---------------- monitor / MVM model state ----------------
    int   m_mode = 0, m_idx = 0, m_lm_cyc = 0, m_vec_end = 0, m_dcyc = -100;
    int   m_pulses = 0, m_base = 0, m_exp_count = 0;
    bit   m_have_job = 0, m_prev_pulse = 0, m_inc_pending = 0, m_vec_done = 0;
    job_t m_cur;
    logic signed [B-1:0] cap_a [K*K];
    logic signed [B-1:0] cap_x [K];
    logic signed [B-1:0] mdl_a [K*K];
    longint y_e, y_o;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_mode = 0; m_have_job = 0; waiting = 0; m_prev_pulse = 0;
                m_inc_pending = 0; m_exp_count = 0; m_dcyc = -100; m_vec_done = 0;
                continue;
            end
            if (m_inc_pending) begin
                m_exp_count = (m_exp_count + 1) % 65536;
                m_inc_pending = 0;
            end
            check("job_count", job_count, m_exp_count);

            m_pulses = int'(mvm_load_matrix) + int'(mvm_load_vector) + int'(mvm_start);
            if (m_pulses != 0) begin
                check("pulse_exclusive", m_pulses, 1);
                check("pulse_spacing", m_prev_pulse, 0);
            end
            m_prev_pulse = (m_pulses != 0);

            if (m_mode != 0) begin
                check("stream_no_pulse", m_pulses, 0);
                m_base = (m_mode == 2 && m_cur.with_mat) ? K * K : 0;
                check(m_mode == 1 ? "mat_word" : "vec_word", mvm_data,
                      longint'($signed(m_cur.w[m_base + m_idx])));
                if (m_mode == 1) cap_a[m_idx] = mvm_data;
                else             cap_x[m_idx] = mvm_data;
                m_idx++;
                if (m_mode == 1 && m_idx == K * K) m_mode = 0;
                else if (m_mode == 2 && m_idx == K) begin
                    m_mode = 0; m_vec_end = cyc; m_vec_done = 1;
                end
            end else begin
                check("data_idle_zero", mvm_data, 0);
                if (mvm_load_matrix) begin
                    check("lm_expected", (exp_q.size() > 0) && !m_have_job, 1);
                    if (exp_q.size() > 0) begin m_cur = exp_q.pop_front(); m_have_job = 1; end
                    check("lm_job_has_matrix", m_cur.with_mat, 1);
                    check("lm_after_last_word", cyc, last_acc_cyc + 1);
                    m_lm_cyc = cyc; m_mode = 1; m_idx = 0; m_vec_done = 0;
                end
                if (mvm_load_vector) begin
                    if (!m_have_job) begin
                        check("lv_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin m_cur = exp_q.pop_front(); m_have_job = 1; end
                        check("lv_job_vector_only", m_cur.with_mat, 0);
                        check("lv_after_last_word", cyc, last_acc_cyc + 1);
                    end else begin
                        check("lv_after_matrix", cyc, m_lm_cyc + K * K + 1);
                    end
                    m_mode = 2; m_idx = 0; m_vec_done = 0;
                end
                if (mvm_start) begin
                    check("start_has_job", m_have_job && m_vec_done, 1);
                    check("start_after_vec", cyc - m_vec_end, 2);
                    if (m_cur.with_mat) begin
                        check("lm_to_start", cyc - m_lm_cyc, K * K + K + 3);
                        for (int i = 0; i < K * K; i++) mdl_a[i] = $signed(m_cur.w[i]);
                    end
                    m_base = m_cur.with_mat ? K * K : 0;
                    for (int r = 0; r < K; r++) begin
                        y_e = 0; y_o = 0;
                        for (int c = 0; c < K; c++) begin
                            y_e += longint'(mdl_a[r*K+c]) * longint'($signed(m_cur.w[m_base + c]));
                            y_o += longint'(cap_a[r*K+c]) * longint'(cap_x[c]);
                        end
                        check("mvm_y", y_o, y_e);
                    end
                    m_have_job = 0; waiting = 1;
                    done_delay = $urandom_range(12, 0); done_pending = 1;
                end
            end

            if (mvm_done && waiting) begin
                waiting = 0; m_inc_pending = 1; m_dcyc = cyc;
            end
            if (cyc == m_dcyc + DRAIN) begin
                check("drain_busy", busy, 1);
                check("drain_ready", s_ready, 0);
            end
            if (cyc == m_dcyc + DRAIN + 1) begin
                check("post_drain_busy", busy, 0);
                check("post_drain_ready", s_ready, 1);
            end
        end
    end

    // MVM done responder, plus occasional stray done pulses while ingesting.
    initial begin
        forever begin
            @(posedge clk); #1;
            mvm_done = 1'b0;
            if (reset) done_pending = 0;
            else if (done_pending != 0) begin
                if (done_delay == 0) begin mvm_done = 1'b1; done_pending = 0; end
                else done_delay--;
            end else if (spurious_en && s_ready && $urandom_range(5, 0) == 0) mvm_done = 1'b1;
        end
    end

    // pat 0: words 1..n, pat 1: identity matrix + 65..72, otherwise random; gap idle cycles per word
    task automatic send_job(input bit wm, input int pat, input int gap);
        job_t j;
        int   n, t;
        n = wm ? JW : K;
        j = '0;
        j.with_mat = wm;
        for (int i = 0; i < n; i++) begin
            case (pat)
                0:       j.w[i] = B'(i + 1);
                1:       j.w[i] = (i < K * K) ? ((i / K == i % K) ? B'(1) : B'(0)) : B'(65 + i - K * K);
                default: j.w[i] = B'($urandom);
            endcase
        end
        exp_q.push_back(j);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            s_valid    = 1'b1;
            s_data     = j.w[i];
            s_with_mat = (i == 0) ? wm : 1'($urandom);
            t = 0;
            while (!s_ready && t < TMO) begin @(posedge clk); #1; t++; end
            if (t >= TMO) begin
                check("ingest_timeout", t, 0);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == n - 1) last_acc_cyc = cyc - 1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || waiting || busy || done_pending != 0) && t < TMO) begin
            @(posedge clk); #1; t++;
        end
        check("idle_reached", t < TMO, 1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 20; c++) begin
            check("idle_s_ready", s_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_pulses", {mvm_load_matrix, mvm_load_vector, mvm_start}, 0);
            check("idle_job_count", job_count, 0);
            @(posedge clk); #1;
        end

        // Full job 1..72, then vector-only and a throttled identity job back to back
        send_job(1'b1, 0, 0);
        send_job(1'b0, 0, 0);
        send_job(1'b1, 1, 2);
        wait_idle();

        // Abort a full job at matrix word 30; send_job returns in the load_matrix cycle
        send_job(1'b1, 2, 0);
        repeat (31) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_s_ready", s_ready, 1);
        check("abort_pulses", {mvm_load_matrix, mvm_load_vector, mvm_start}, 0);
        check("abort_data", mvm_data, 0);
        check("abort_busy", busy, 0);
        check("abort_job_count", job_count, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Randomised jobs with stray done pulses; the first must load a matrix
        spurious_en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            send_job((n == 0) ? 1'b1 : 1'($urandom_range(1, 0)), 2, $urandom_range(2, 0));
            if ($urandom_range(2, 0) == 0) wait_idle();
        end
        wait_idle();
        spurious_en = 1'b0;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
